// File: rtl/fpadd_align_ctrl.sv
// ---------------------------------------------------------------------------
// fpadd_align_ctrl
//   Alignment-stage sequencer for the single-precision FP adder. It accepts
//   one operand pair, orders the two operands by magnitude and works out a
//   saturated right-shift amount. It then aligns the smaller mantissa with its
//   own shifter and holds the result until the add/normalise stage takes it.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand pair valid
//   in_ready   : controller idle and able to take a pair
//   op_a/op_b  : IEEE-754 single operands
//   out_valid  : aligned result valid (HOLD state)
//   out_ready  : downstream accepts the result
//   sign_big   : sign of larger-magnitude operand
//   sign_small : sign of smaller-magnitude operand
//   exp_big    : effective exponent of larger operand
//   man_big    : {hidden, frac, 3'b000}
//   man_small  : aligned smaller mantissa {shifted 26 bits, sticky}
//   swap       : 1 when operand B was the larger one
//   special    : either operand has exponent 255
// ---------------------------------------------------------------------------

// Right shifter for the smaller mantissa. Two zero bits are appended below
// the mantissa, and everything shifted past them is folded into a sticky bit.
module fpadd_align_shifter (
  input  logic [23:0] i_man,
  input  logic [4:0]  i_shamt,
  output logic [26:0] o_man
);
  logic [25:0] w_g;
  logic [31:0] w_mask;
  logic        w_sticky;

  assign w_g = {i_man, 2'b00};
  // Build the mask in 32 bits so that shifts of 26..31 still cover all of g.
  assign w_mask   = (32'd1 << i_shamt) - 32'd1;
  assign w_sticky = |({6'd0, w_g} & w_mask);
  assign o_man    = {w_g >> i_shamt, w_sticky};
endmodule

module fpadd_align_ctrl #(
  parameter int unsigned SHAMT_SAT = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_big,
  output logic        sign_small,
  output logic [7:0]  exp_big,
  output logic [26:0] man_big,
  output logic [26:0] man_small,
  output logic        swap,
  output logic        special
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMP   = 2'd1;
  localparam logic [1:0] ALIGN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] SAT_DIFF  = 8'(SHAMT_SAT);
  localparam logic [4:0] SAT_SHAMT = 5'(SHAMT_SAT);

  logic [1:0]  r_state;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic        r_swapCmp;
  logic        r_specialCmp;
  logic [4:0]  r_shamt;
  logic        r_signBig;
  logic        r_signSmall;
  logic [7:0]  r_expBig;
  logic [26:0] r_manBig;
  logic [26:0] r_manSmall;
  logic        r_swap;
  logic        r_special;

  logic [7:0]  w_expA;
  logic [7:0]  w_expB;
  logic        w_hidA;
  logic        w_hidB;
  logic [7:0]  w_effExpA;
  logic [7:0]  w_effExpB;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic        w_bGreater;
  logic        w_special;
  logic [7:0]  w_diff;
  logic [4:0]  w_shamtNext;
  logic [23:0] w_smallMan;
  logic [26:0] w_shiftOut;

  // Unpack the registered operands. Denormals and zeros use an effective
  // exponent of 1 with no hidden bit.
  assign w_expA    = r_opA[30:23];
  assign w_expB    = r_opB[30:23];
  assign w_hidA    = (w_expA != 8'd0);
  assign w_hidB    = (w_expB != 8'd0);
  assign w_effExpA = w_hidA ? w_expA : 8'd1;
  assign w_effExpB = w_hidB ? w_expB : 8'd1;
  assign w_magA    = {w_effExpA, w_hidA, r_opA[22:0]};
  assign w_magB    = {w_effExpB, w_hidB, r_opB[22:0]};

  // A tie keeps A as the big operand.
  assign w_bGreater = (w_magB > w_magA);
  assign w_special  = (w_expA == 8'hFF) | (w_expB == 8'hFF);
  assign w_diff     = w_bGreater ? (w_effExpB - w_effExpA) : (w_effExpA - w_effExpB);

  // Inf/NaN operands pass through unshifted; large gaps saturate.
  always_comb begin
    w_shamtNext = w_diff[4:0];
    if (w_special) begin
      w_shamtNext = 5'd0;
    end else if (w_diff >= SAT_DIFF) begin
      w_shamtNext = SAT_SHAMT;
    end
  end

  assign w_smallMan = r_swapCmp ? {w_hidA, r_opA[22:0]} : {w_hidB, r_opB[22:0]};

  fpadd_align_shifter u_shifter (
    .i_man   (w_smallMan),
    .i_shamt (r_shamt),
    .o_man   (w_shiftOut)
  );

  // Sequencer: IDLE -> CMP -> ALIGN -> HOLD -> IDLE. The data outputs load
  // only in ALIGN, so they keep their value through HOLD and afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_opA        <= 32'd0;
      r_opB        <= 32'd0;
      r_swapCmp    <= 1'b0;
      r_specialCmp <= 1'b0;
      r_shamt      <= 5'd0;
      r_signBig    <= 1'b0;
      r_signSmall  <= 1'b0;
      r_expBig     <= 8'd0;
      r_manBig     <= 27'd0;
      r_manSmall   <= 27'd0;
      r_swap       <= 1'b0;
      r_special    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= op_a;
            r_opB   <= op_b;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_swapCmp    <= w_bGreater;
          r_specialCmp <= w_special;
          r_shamt      <= w_shamtNext;
          r_state      <= ALIGN;
        end
        ALIGN: begin
          r_manSmall <= w_shiftOut;
          if (r_swapCmp) begin
            r_manBig    <= {w_hidB, r_opB[22:0], 3'b000};
            r_expBig    <= w_effExpB;
            r_signBig   <= r_opB[31];
            r_signSmall <= r_opA[31];
          end else begin
            r_manBig    <= {w_hidA, r_opA[22:0], 3'b000};
            r_expBig    <= w_effExpA;
            r_signBig   <= r_opA[31];
            r_signSmall <= r_opB[31];
          end
          r_swap    <= r_swapCmp;
          r_special <= r_specialCmp;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == HOLD);
  assign sign_big   = r_signBig;
  assign sign_small = r_signSmall;
  assign exp_big    = r_expBig;
  assign man_big    = r_manBig;
  assign man_small  = r_manSmall;
  assign swap       = r_swap;
  assign special    = r_special;

endmodule

// File: tb/tb_fpadd_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpadd_align_ctrl
//   Self-checking bench for fpadd_align_ctrl. A table of operand pairs with
//   hand-derived aligned results is applied through the handshake. Expected
//   records are queued on acceptance and popped when out_valid appears.
//   Hand-written sequences cover backpressure and reset during ALIGN.
// ---------------------------------------------------------------------------
module tb_fpadd_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_big;
  logic        sign_small;
  logic [7:0]  exp_big;
  logic [26:0] man_big;
  logic [26:0] man_small;
  logic        swap;
  logic        special;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        signBig;
    logic        signSmall;
    logic [7:0]  expBig;
    logic [26:0] manBig;
    logic [26:0] manSmall;
    logic        swp;
    logic        spec;
  } vec_t;

  localparam int NUM_VECS = 14;
  vec_t vecs[NUM_VECS];
  vec_t sbQ[$];

  always #5 clk = ~clk;

  fpadd_align_ctrl #(.SHAMT_SAT(26)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .exp_big    (exp_big),
    .man_big    (man_big),
    .man_small  (man_small),
    .swap       (swap),
    .special    (special)
  );

  function automatic vec_t mkVec(input logic [31:0] a, input logic [31:0] b,
                                 input logic sb, input logic ss, input logic [7:0] e,
                                 input logic [26:0] mb, input logic [26:0] ms,
                                 input logic sw, input logic sp);
    vec_t v;
    v.a = a; v.b = b; v.signBig = sb; v.signSmall = ss; v.expBig = e;
    v.manBig = mb; v.manSmall = ms; v.swp = sw; v.spec = sp;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkData(input string tag, input vec_t e);
    checkField({tag, " sign_big"},   32'(sign_big),   32'(e.signBig));
    checkField({tag, " sign_small"}, 32'(sign_small), 32'(e.signSmall));
    checkField({tag, " exp_big"},    32'(exp_big),    32'(e.expBig));
    checkField({tag, " man_big"},    32'(man_big),    32'(e.manBig));
    checkField({tag, " man_small"},  32'(man_small),  32'(e.manSmall));
    checkField({tag, " swap"},       32'(swap),       32'(e.swp));
    checkField({tag, " special"},    32'(special),    32'(e.spec));
  endtask

  // Present a pair and return just after the rising edge that accepts it.
  task automatic applyStimulus(input vec_t v, input bit pushExp);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = v.a;
    op_b = v.b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkField("accept_seen", 32'(seen), 32'd1);
    @(posedge clk);
    if (pushExp) sbQ.push_back(v);
  endtask

  // Wait for the result, compare it with the scoreboard, optionally hold off
  // the downstream while offering another pair, then complete the handshake.
  task automatic checkOutput(input string tag, input int holdCycles,
                             input logic [31:0] nextA, input logic [31:0] nextB);
    int n;
    bit seen;
    vec_t e;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkField({tag, " out_valid_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    checkField({tag, " latency"}, 32'(n), 32'd3);
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard actual=empty required=entry", tag);
      return;
    end
    e = sbQ.pop_front();
    checkData(tag, e);
    for (int k = 0; k < holdCycles; k++) begin
      in_valid = 1'b1;
      op_a = nextA;
      op_b = nextB;
      @(negedge clk);
      checkField({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      checkField({tag, " hold in_ready"},  32'(in_ready),  32'd0);
      checkField({tag, " hold man_small"}, 32'(man_small), 32'(e.manSmall));
      checkField({tag, " hold exp_big"},   32'(exp_big),   32'(e.expBig));
      checkField({tag, " hold man_big"},   32'(man_big),   32'(e.manBig));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkField({tag, " done out_valid"},  32'(out_valid), 32'd0);
    checkField({tag, " done in_ready"},   32'(in_ready),  32'd1);
    checkField({tag, " kept man_small"},  32'(man_small), 32'(e.manSmall));
    checkField({tag, " kept exp_big"},    32'(exp_big),   32'(e.expBig));
  endtask

  initial begin
    vec_t zeroV;
    zeroV = mkVec(32'd0, 32'd0, 1'b0, 1'b0, 8'h00, 27'h0, 27'h0, 1'b0, 1'b0);

    //                a             b             sB    sS    expBig  manBig        manSmall      swap  spec
    vecs[0]  = mkVec(32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
    vecs[1]  = mkVec(32'h41000000, 32'h3F800001, 1'b0, 1'b0, 8'h82, 27'h4000000, 27'h0800001, 1'b0, 1'b0);
    vecs[2]  = mkVec(32'h41000000, 32'h3F800000, 1'b0, 1'b0, 8'h82, 27'h4000000, 27'h0800000, 1'b0, 1'b0);
    vecs[3]  = mkVec(32'h3F800000, 32'h4F000000, 1'b0, 1'b0, 8'h9E, 27'h4000000, 27'h0000001, 1'b1, 1'b0);
    vecs[4]  = mkVec(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b1);
    vecs[5]  = mkVec(32'h00000001, 32'h00000000, 1'b0, 1'b0, 8'h01, 27'h0000008, 27'h0000000, 1'b0, 1'b0);
    vecs[6]  = mkVec(32'hBF800000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0);
    vecs[7]  = mkVec(32'h4C000000, 32'h3F800000, 1'b0, 1'b0, 8'h98, 27'h4000000, 27'h0000002, 1'b0, 1'b0);
    vecs[8]  = mkVec(32'h4C800000, 32'h3F800000, 1'b0, 1'b0, 8'h99, 27'h4000000, 27'h0000001, 1'b0, 1'b0);
    vecs[9]  = mkVec(32'h3F800000, 32'hC0000000, 1'b1, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b0);
    vecs[10] = mkVec(32'h4F000000, 32'h00000000, 1'b0, 1'b0, 8'h9E, 27'h4000000, 27'h0000000, 1'b0, 1'b0);
    vecs[11] = mkVec(32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 8'hFF, 27'h6000000, 27'h4000000, 1'b1, 1'b1);
    vecs[12] = mkVec(32'h00800000, 32'h00400000, 1'b0, 1'b0, 8'h01, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
    vecs[13] = mkVec(32'h4C000000, 32'h3F800001, 1'b0, 1'b0, 8'h98, 27'h4000000, 27'h0000003, 1'b0, 1'b0);

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkField("reset in_ready",  32'(in_ready),  32'd1);
    checkField("reset out_valid", 32'(out_valid), 32'd0);
    checkData("reset", zeroV);
    rst_n = 1'b1;

    // Table vectors; odd entries raise out_ready before out_valid appears.
    for (int i = 0; i < NUM_VECS; i++) begin
      out_ready = (i % 2 == 1);
      applyStimulus(vecs[i], 1'b1);
      checkOutput($sformatf("vec%0d", i), 0, 32'd0, 32'd0);
    end

    // Backpressure: a new pair is offered for 5 HOLD cycles and must wait.
    applyStimulus(vecs[0], 1'b1);
    checkOutput("bp_first", 5, vecs[1].a, vecs[1].b);
    sbQ.push_back(vecs[1]);
    @(posedge clk);
    checkOutput("bp_next", 0, 32'd0, 32'd0);

    // Reset while in ALIGN drops the pair.
    applyStimulus(vecs[3], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkField("abort align out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkField("abort in_ready",  32'(in_ready),  32'd1);
    checkField("abort out_valid", 32'(out_valid), 32'd0);
    checkData("abort", zeroV);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkField("abort no out_valid", 32'(out_valid), 32'd0);
    end

    // Normal operation resumes after the abort.
    applyStimulus(vecs[2], 1'b1);
    checkOutput("post_abort", 0, 32'd0, 32'd0);

    checkField("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
